multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style control sequencer for a multicycle RV32I-subset core; replaces single-cycle main decoder.
- Drives ImmSrc of the immediate extender plus all datapath mux selects, register/memory/PC/IR write enables and ALUControl.
- Holds on a memory ready handshake at every memory-access state.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter InstrRet.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; forces FETCH and clears the counter.
- op  input  7  opcode from instruction register, instr[6:0].
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access complete this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction/OldPC register enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  to immediate extender: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  ALU operation code.
- RegWrite  output  1  register file write enable.
- State  output  4  current state encoding, for debug.
- InstrRet  output  CNT_W  retired-instruction count.

Behaviour:
State encoding (4'd): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.

Reset:
- State = FETCH; InstrRet = 0.
- Outputs equal the FETCH decode, with IRWrite and PCWrite gated by MemReady.

Transitions (registered on clk):
- FETCH -> DECODE when MemReady=1; otherwise stay in FETCH.
- DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH (see feature).
- MEMADR -> MEMREAD if op=0000011; -> MEMWRITE if op=0100011.
- MEMREAD -> MEMWB on MemReady; otherwise stay.
- MEMWRITE -> FETCH on MemReady; otherwise stay.
- EXECUTER and EXECUTEI -> ALUWB; JAL -> ALUWB.
- MEMWB, ALUWB, BEQ -> FETCH.

Per-state outputs (all unlisted enables are 0):
- FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held for the whole wait.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.

Derived signals:
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is combinational from op in every state: lw/I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
- ALU decoder: ALUOp 00 -> 000 (add); 01 -> 001 (sub).
- ALUOp 10 by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); others -> 000.

Counter:
- InstrRet increments by 1 on the cycle that leaves MEMWB, ALUWB, BEQ or MEMWRITE (with MemReady=1) to FETCH.
- Wraps modulo 2^CNT_W.

Boundary conditions:
- Reset asserted in any state, including mid-wait: State = FETCH and InstrRet = 0 next cycle; no partial instruction is retired.
- Reset has priority over all transitions.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported op in DECODE -> TRAP. TRAP asserts no enables, stays in TRAP until reset, and does not count.
- Undefined: an unsupported op in DECODE -> FETCH as a NOP, not counted. TRAP is unreachable.

Test Plan:
- Reset, MemReady=1, then add (op 0110011, funct3 000, funct7b5 0) -> states 0,1,6,8,0; ALUControl=000 in state 6; RegWrite=1 only in state 8; InstrRet=1.
- lw (op 0000011), MemReady held low 3 cycles in MEMREAD -> stays in state 3 for 3 extra cycles, AdrSrc=1 throughout; MEMWB has ResultSrc=01; ImmSrc=00.
- sw (op 0100011) -> ImmSrc=01; MemWrite=1 only in state 5; next state FETCH; no RegWrite; InstrRet increments.
- beq with Zero=1, then with Zero=0 -> ImmSrc=10, ALUControl=001; PCWrite=1 in BEQ only when Zero=1.
- jal (op 1101111) -> ImmSrc=11; PCWrite=1 in JAL; ALUWB RegWrite=1; sub (funct7b5=1, op[5]=1) -> ALUControl=001.
- op 0000000 with and without CTRL_ILLEGAL_TRAP_EN -> State sticks at 11 vs. returns to 0; reset asserted in state 11 -> State 0, InstrRet 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore-style control sequencer for a multicycle RV32I-subset core. From the
// current state it drives the datapath mux selects, the register, memory, PC
// and IR write enables and the ALU operation. Every memory-access state waits
// on the MemReady handshake. Retired instructions are counted in InstrRet.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an unsupported opcode in DECODE enters TRAP. TRAP asserts no
//               enables and is left only by reset.
//   undefined : an unsupported opcode in DECODE returns to FETCH as a NOP
//               that is not counted. TRAP cannot be reached.
//
// Parameters:
//   CNT_W       width of the retired-instruction counter
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset (FETCH, counter cleared)
//   op          instr[6:0] opcode
//   funct3      instr[14:12]
//   funct7b5    instr[30]
//   Zero        ALU zero flag
//   MemReady    memory access completes this cycle
//   PCWrite     PC register enable
//   AdrSrc      memory address select (0 PC, 1 ALU result)
//   MemWrite    data memory write strobe
//   IRWrite     instruction / OldPC register enable
//   ResultSrc   result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA     ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB     ALU B select (00 rs2, 01 ImmExt, 10 constant 4)
//   ImmSrc      immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUControl  ALU operation code
//   RegWrite    register file write enable
//   State       current state encoding, for debug
//   InstrRet    retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrRet
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_instr_ret;
    logic [3:0]       w_next_state;
    logic             w_retire;
    logic [1:0]       w_alu_op;
    logic             w_branch;
    logic             w_pc_update;

    // Next-state selection.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (MemReady) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYP:      w_next_state = S_EXECUTER;
                    OP_ITYP:      w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      w_next_state = S_TRAP;
`else
                    default:      w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                // The IR is stable here, so op is still lw or sw.
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else if (op == OP_SW) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMREAD: begin
                if (MemReady) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: w_next_state = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       w_next_state = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:                        w_next_state = S_TRAP;
`endif
            default:                       w_next_state = S_FETCH;
        endcase
    end

    // An instruction retires on the cycle it returns to FETCH after real work.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_BEQ: w_retire = 1'b1;
            S_MEMWRITE:              w_retire = MemReady;
            default:                 w_retire = 1'b0;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_instr_ret <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instr_ret <= r_instr_ret + CNT_ONE;
            end else begin
                r_instr_ret <= r_instr_ret;
            end
        end
    end

    // Per-state datapath controls; FETCH enables follow the memory handshake.
    always_comb begin
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        RegWrite    = 1'b0;
        w_branch    = 1'b0;
        w_pc_update = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = MemReady;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = MemReady;
            end
            S_DECODE: begin
                // Precompute the branch target OldPC + ImmExt.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_ITYP: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_JAL:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder; sub needs op[5] so that addi with imm[10]=1 stays an add.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] & funct7b5) begin
                            ALUControl = 3'b001;
                        end else begin
                            ALUControl = 3'b000;
                        end
                    end
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    assign PCWrite  = w_pc_update | (w_branch & Zero);
    assign State    = r_state;
    assign InstrRet = r_instr_ret;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm. Inputs change 2 time units after
// the rising edge and outputs are checked before the next edge. Expected
// values are hand-derived constants; exp_ret tracks the retired count.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        RegWrite;
    logic [3:0]  State;
    logic [31:0] InstrRet;

    int n_checks;
    int n_fail;
    int exp_ret;

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .State      (State),
        .InstrRet   (InstrRet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ret  = 0;
        reset    = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        // Reset state: FETCH decode with handshake-gated enables low.
        chk("rst_state", {28'd0, State}, 32'd0);
        chk("rst_ret", InstrRet, 32'd0);
        chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        chk("rst_srcb", {30'd0, ALUSrcB}, 32'd2);
        chk("rst_result", {30'd0, ResultSrc}, 32'd2);
        // FETCH stalls while memory is not ready.
        tick();
        chk("fetch_stall", {28'd0, State}, 32'd0);
        MemReady = 1'b1;
        #1;
        chk("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("fetch_pcwrite", {31'd0, PCWrite}, 32'd1);

        // add
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        tick();
        chk("add_s1", {28'd0, State}, 32'd1);
        chk("add_dec_srca", {30'd0, ALUSrcA}, 32'd1);
        chk("add_dec_srcb", {30'd0, ALUSrcB}, 32'd1);
        tick();
        chk("add_s6", {28'd0, State}, 32'd6);
        chk("add_aluctl", {29'd0, ALUControl}, 32'd0);
        chk("add_s6_regwr", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("add_s8", {28'd0, State}, 32'd8);
        chk("add_s8_regwr", {31'd0, RegWrite}, 32'd1);
        tick();
        exp_ret = exp_ret + 1;
        chk("add_s0", {28'd0, State}, 32'd0);
        chk("add_ret", InstrRet, exp_ret);

        // lw with a 3-cycle MEMREAD wait
        op = 7'b0000011;
        tick();
        chk("lw_imm", {30'd0, ImmSrc}, 32'd0);
        tick();
        chk("lw_s2", {28'd0, State}, 32'd2);
        MemReady = 1'b0;
        tick();
        chk("lw_s3", {28'd0, State}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_wait_state", {28'd0, State}, 32'd3);
            chk("lw_wait_adrsrc", {31'd0, AdrSrc}, 32'd1);
        end
        MemReady = 1'b1;
        tick();
        chk("lw_s4", {28'd0, State}, 32'd4);
        chk("lw_result", {30'd0, ResultSrc}, 32'd1);
        chk("lw_regwr", {31'd0, RegWrite}, 32'd1);
        tick();
        exp_ret = exp_ret + 1;
        chk("lw_ret", InstrRet, exp_ret);

        // sw with one wait cycle in MEMWRITE
        op = 7'b0100011;
        tick();
        chk("sw_imm", {30'd0, ImmSrc}, 32'd1);
        tick();
        chk("sw_s2_memwr", {31'd0, MemWrite}, 32'd0);
        MemReady = 1'b0;
        tick();
        chk("sw_s5", {28'd0, State}, 32'd5);
        chk("sw_memwr", {31'd0, MemWrite}, 32'd1);
        chk("sw_regwr", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("sw_hold_state", {28'd0, State}, 32'd5);
        chk("sw_hold_memwr", {31'd0, MemWrite}, 32'd1);
        chk("sw_hold_ret", InstrRet, exp_ret);
        MemReady = 1'b1;
        tick();
        exp_ret = exp_ret + 1;
        chk("sw_s0", {28'd0, State}, 32'd0);
        chk("sw_ret", InstrRet, exp_ret);
        chk("sw_s0_memwr", {31'd0, MemWrite}, 32'd0);

        // beq, Zero toggled inside BEQ
        op = 7'b1100011; Zero = 1'b1;
        tick();
        chk("beq_imm", {30'd0, ImmSrc}, 32'd2);
        chk("beq_dec_pcwr", {31'd0, PCWrite}, 32'd0);
        tick();
        chk("beq_s9", {28'd0, State}, 32'd9);
        chk("beq_aluctl", {29'd0, ALUControl}, 32'd1);
        chk("beq_taken", {31'd0, PCWrite}, 32'd1);
        Zero = 1'b0;
        #1;
        chk("beq_not_taken", {31'd0, PCWrite}, 32'd0);
        tick();
        exp_ret = exp_ret + 1;
        chk("beq_ret", InstrRet, exp_ret);

        // jal
        op = 7'b1101111;
        tick();
        chk("jal_imm", {30'd0, ImmSrc}, 32'd3);
        tick();
        chk("jal_s10", {28'd0, State}, 32'd10);
        chk("jal_pcwr", {31'd0, PCWrite}, 32'd1);
        tick();
        chk("jal_s8_regwr", {31'd0, RegWrite}, 32'd1);
        tick();
        exp_ret = exp_ret + 1;
        chk("jal_ret", InstrRet, exp_ret);

        // sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick();
        tick();
        chk("sub_aluctl", {29'd0, ALUControl}, 32'd1);
        tick();
        tick();
        exp_ret = exp_ret + 1;

        // I-type ALU decode: addi with funct7b5 set stays add
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick();
        tick();
        chk("addi_s7", {28'd0, State}, 32'd7);
        chk("addi_aluctl", {29'd0, ALUControl}, 32'd0);
        funct3 = 3'b010; #1;
        chk("slti_aluctl", {29'd0, ALUControl}, 32'd5);
        funct3 = 3'b110; #1;
        chk("ori_aluctl", {29'd0, ALUControl}, 32'd3);
        funct3 = 3'b111; #1;
        chk("andi_aluctl", {29'd0, ALUControl}, 32'd2);
        funct3 = 3'b001; #1;
        chk("other_aluctl", {29'd0, ALUControl}, 32'd0);
        tick();
        tick();
        exp_ret = exp_ret + 1;
        chk("itype_ret", InstrRet, exp_ret);

        // Unsupported opcode
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
        tick();
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill_trap", {28'd0, State}, 32'd11);
        tick();
        chk("ill_trap_stick", {28'd0, State}, 32'd11);
        chk("ill_trap_pcwr", {31'd0, PCWrite}, 32'd0);
        chk("ill_trap_regwr", {31'd0, RegWrite}, 32'd0);
        chk("ill_trap_ret", InstrRet, exp_ret);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ret = 0;
        chk("trap_rst_state", {28'd0, State}, 32'd0);
        chk("trap_rst_ret", InstrRet, exp_ret);
`else
        chk("ill_nop", {28'd0, State}, 32'd0);
        chk("ill_nop_ret", InstrRet, exp_ret);
`endif

        // Reset during a MEMREAD wait has priority and retires nothing.
        Zero = 1'b0; MemReady = 1'b1; op = 7'b0000011;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        chk("mid_s3", {28'd0, State}, 32'd3);
        reset = 1'b1; MemReady = 1'b1;
        tick();
        reset = 1'b0; MemReady = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, State}, 32'd0);
        chk("mid_rst_ret", InstrRet, 32'd0);

        // Reset has priority over a retiring ALUWB.
        MemReady = 1'b1; op = 7'b0110011;
        tick();
        tick();
        tick();
        chk("pri_s8", {28'd0, State}, 32'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pri_state", {28'd0, State}, 32'd0);
        chk("pri_ret", InstrRet, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
